cam_dvp2axis: RTL and testbench
===============================

Name: cam_dvp2axis

Overview:
- Camera capture front end for the OV5640 DVP port, running entirely in the CAM_PCLK domain.
- Pairs 8-bit RGB565 bytes into pixels, expands them to 24-bit RGB888, and emits AXI4-Stream video with tuser on start-of-frame and tlast on end-of-line.
- Its output feeds the VDMA S2MM input (the axis_i stream). Its status words feed the register block.

Parameters:
- FIFO_DEPTH, 16: output FIFO depth in pixels; power of 2, minimum 4.
- SKIP_FRAMES, 2: number of frames discarded after capture is enabled (sensor settling).
- CNT_WID, 12: width of the line and pixel counters.

Ports:
- clk  in  1  CAM_PCLK
- rst  in  1  synchronous reset, active high
- cap_en  in  1  capture enable; sampled only at frame boundaries
- ovf_clr  in  1  one-cycle pulse; clears the sticky overflow and odd-byte flags
- cam_vsync  in  1  OV5640 VSYNC, high during vertical blank
- cam_href  in  1  OV5640 HREF, high while line bytes are valid
- cam_data  in  8  OV5640 data
- m_axis_tdata  out  24  pixel; [23:16]=R, [15:8]=B, [7:0]=G
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- m_axis_tuser  out  1  first pixel of frame
- m_axis_tlast  out  1  last pixel of line
- m_axis_tkeep  out  3  constant 3'b111
- frame_cnt  out  16  frames forwarded; wraps
- line_cnt  out  CNT_WID  lines in the last completed frame
- pix_cnt  out  CNT_WID  pixels in the last completed line
- ovf  out  1  sticky FIFO overflow
- odd_err  out  1  sticky flag: a line had an odd byte count

Behaviour:
- Reset values: all outputs 0 except m_axis_tkeep. State = S_IDLE. FIFO empty. Byte phase 0. Skip counter = SKIP_FRAMES.
- Input stage: cam_vsync, cam_href and cam_data are registered once. All logic below uses the registered copies; vsync and href edges are detected against a second register.
- State machine:
  - S_IDLE: when vsync is high and cap_en is 1, go to S_VBLANK.
  - S_VBLANK: on vsync falling edge:
    - If skip counter is nonzero, decrement it and go to S_SKIP.
    - Otherwise go to S_ACTIVE and arm the sof flag.
  - S_SKIP: bytes are ignored. On vsync rising edge, go to S_VBLANK, or to S_IDLE if cap_en is 0.
  - S_ACTIVE: bytes are captured. On vsync rising edge:
    - Flush any held pixel.
    - Latch line_cnt and increment frame_cnt.
    - Go to S_VBLANK if cap_en is 1. Otherwise go to S_IDLE and reload the skip counter.
- Byte pairing (S_ACTIVE only):
  - Byte phase toggles on each byte with href high, and is cleared while href is low.
  - Phase 0 byte is {R[4:0], G[5:3]}. Phase 1 byte is {G[2:0], B[4:0]}; it completes a pixel.
- Expansion to 8 bits per channel:
  - R8 = {R5, R5[4:2]}
  - G8 = {G6, G6[5:4]}
  - B8 = {B5, B5[4:2]}
- Hold-one pixel (generates tlast without knowing line length):
  - A completed pixel goes into a hold register.
  - When the next pixel completes, the held pixel is pushed with tlast=0.
  - On the href falling edge, the held pixel is pushed with tlast=1.
  - tuser=1 on the first push after sof is armed; sof then clears.
  - Latency: a pixel is pushed one pixel-time after completion. An end-of-line pixel is pushed 2 clk after its second byte.
- Odd byte count: an href falling edge with phase 1 discards the partial byte and sets odd_err. The held pixel is still pushed with tlast.
- Counters:
  - The pixel counter increments per push and clears at line end; pix_cnt latches on tlast pushes.
  - The line counter increments on tlast pushes; line_cnt latches at frame end.
  - Both saturate at all-ones.
- FIFO and overflow:
  - Push when the FIFO is not full. A push while full drops the pixel and sets ovf.
  - A dropped tlast or tuser pixel is lost. No recovery within the frame; the downstream VDMA resyncs on the next tuser.
  - The stream is driven from the FIFO head, first-word-fall-through.
  - A pop occurs when tvalid and tready are both 1. Simultaneous push and pop while full is allowed; no overflow is recorded.
- Flags: ovf and odd_err clear on ovf_clr. If a set event and ovf_clr occur in the same cycle, set wins.
- Reset mid-frame: the FIFO is flushed and tvalid drops the next cycle; capture resumes only after a full vsync cycle.
- cap_en deassertion mid-frame: the current frame completes.

Decomposition:
- Package cam_pkg: state enum (S_IDLE, S_VBLANK, S_SKIP, S_ACTIVE), the RGB565 field bit positions, and a 26-bit FIFO word struct {tuser, tlast, tdata}.
- Sub-module sync_fifo_fwft (parameters WID and DEPTH; outputs full and empty). Its clock and reset follow the same conventions as this block.

Test Plan:
- 2 lines of 4 pixels, pixel 0x F800 (red), tready=1, SKIP_FRAMES=0 -> tdata 0xFF0000. Exactly 8 beats; tuser on beat 0 only; tlast on beats 3 and 7. After vsync rises: line_cnt=2, pix_cnt=4, frame_cnt=1.
- SKIP_FRAMES=2, 3 frames sent -> only frame 3 appears; frame_cnt=1.
- Line of 5 bytes -> 2 pixels, the second with tlast; odd_err=1; ovf_clr pulse -> odd_err=0.
- tready=0 for a 32-pixel line with FIFO_DEPTH=16 -> 16 beats stored, ovf=1. After tready=1, 16 beats drain, none with tlast.
- cap_en dropped mid-frame 1 -> frame 1 completes with its final tlast; no tuser follows; state returns to S_IDLE.
- rst asserted mid-line -> next cycle tvalid=0 and counters=0; the next full frame is captured with tuser on its first beat.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types for the OV5640 DVP capture path: FSM states, RGB565 field
// positions and the word carried through the output FIFO.
package cam_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_VBLANK,
    S_SKIP,
    S_ACTIVE
  } cap_state_e;

  // Field positions inside the assembled 16-bit RGB565 pixel {byte0, byte1}
  localparam int R_HI = 15;
  localparam int R_LO = 11;
  localparam int G_HI = 10;
  localparam int G_LO = 5;
  localparam int B_HI = 4;
  localparam int B_LO = 0;

  typedef struct packed {
    logic        tuser;
    logic        tlast;
    logic [23:0] tdata;
  } fifo_word_t;

  // Bit-replicating expansion; output order is {R8, B8, G8}
  function automatic logic [23:0] rgb565_to_888(input logic [15:0] px);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    r5 = px[R_HI:R_LO];
    g6 = px[G_HI:G_LO];
    b5 = px[B_HI:B_LO];
    return {r5, r5[4:2], b5, b5[4:2], g6, g6[5:4]};
  endfunction

endpackage

// File: rtl/cam_dvp2axis_if.sv
// AXI4-Stream video channel (24-bit RGB888, tuser = SOF, tlast = EOL).
interface cam_dvp2axis_if;
  logic [23:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;
  logic [2:0]  tkeep;

  modport master (output tdata, tvalid, tuser, tlast, tkeep, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, tkeep, output tready);
endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; a write while full is accepted
// only when a read frees a slot in the same cycle.
module sync_fifo_fwft #(
  parameter int WID   = 26,
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic [WID-1:0] wr_data,
  input  logic           rd_en,
  output logic [WID-1:0] rd_data,
  output logic           full,
  output logic           empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WID-1:0] mem [DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic           do_wr, do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: the storage array is deliberately not reset; the pointers alone say which entries are valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/cam_dvp2axis.sv
// OV5640 DVP capture: pairs RGB565 bytes, expands to RGB888 and emits
// AXI4-Stream video with tuser on SOF and tlast on EOL, all in CAM_PCLK.
module cam_dvp2axis
  import cam_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int SKIP_FRAMES = 2,
  parameter int CNT_WID     = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cap_en,
  input  logic               ovf_clr,
  input  logic               cam_vsync,
  input  logic               cam_href,
  input  logic [7:0]         cam_data,
  cam_dvp2axis_if.master     m_axis,
  output logic [15:0]        frame_cnt,
  output logic [CNT_WID-1:0] line_cnt,
  output logic [CNT_WID-1:0] pix_cnt,
  output logic               ovf,
  output logic               odd_err
);

  localparam int SKIP_W = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

  logic       vs_r, vs_d, hr_r, hr_d;
  logic [7:0] d_r;
  logic       vs_rise, vs_fall, hr_fall;

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_r <= 1'b0;
      vs_d <= 1'b0;
      hr_r <= 1'b0;
      hr_d <= 1'b0;
      d_r  <= '0;
    end else begin
      vs_r <= cam_vsync;
      vs_d <= vs_r;
      hr_r <= cam_href;
      hr_d <= hr_r;
      d_r  <= cam_data;
    end
  end

  assign vs_rise = vs_r && !vs_d;
  assign vs_fall = !vs_r && vs_d;
  assign hr_fall = !hr_r && hr_d;

  cap_state_e        state, state_nxt;
  logic [SKIP_W-1:0] skip_cnt;
  logic              go_active, go_skip, frame_end, reload_skip;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt   = state;
    go_active   = 1'b0;
    go_skip     = 1'b0;
    frame_end   = 1'b0;
    reload_skip = 1'b0;
    unique case (state)
      S_IDLE:   if (vs_r && cap_en) state_nxt = S_VBLANK;
      S_VBLANK: if (vs_fall) begin
        if (skip_cnt != '0) begin
          go_skip   = 1'b1;
          state_nxt = S_SKIP;
        end else begin
          go_active = 1'b1;
          state_nxt = S_ACTIVE;
        end
      end
      S_SKIP:   if (vs_rise) state_nxt = cap_en ? S_VBLANK : S_IDLE;
      S_ACTIVE: if (vs_rise) begin
        frame_end = 1'b1;
        if (cap_en) begin
          state_nxt = S_VBLANK;
        end else begin
          state_nxt   = S_IDLE;
          reload_skip = 1'b1;
        end
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || reload_skip) skip_cnt <= SKIP_W'(SKIP_FRAMES);
    else if (go_skip)       skip_cnt <= skip_cnt - SKIP_W'(1);
  end

  logic        active, phase, pix_done, line_end, push, sof;
  logic [7:0]  byte0;
  logic        hold_vld;
  logic [23:0] hold_px;

  assign active   = (state == S_ACTIVE);
  assign pix_done = active && hr_r && phase;
  // A frame end also closes a line so a pixel still held at vsync gets flushed
  assign line_end = active && (hr_fall || vs_rise);
  assign push     = hold_vld && (pix_done || line_end);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= 1'b0;
      byte0    <= '0;
      hold_vld <= 1'b0;
      hold_px  <= '0;
      sof      <= 1'b0;
    end else begin
      phase <= (active && hr_r) ? !phase : 1'b0;
      if (active && hr_r && !phase) byte0 <= d_r;
      if (pix_done) begin
        hold_vld <= 1'b1;
        hold_px  <= rgb565_to_888({byte0, d_r});
      end else if (line_end) begin
        hold_vld <= 1'b0;
      end
      if (go_active) sof <= 1'b1;
      else if (push) sof <= 1'b0;
    end
  end

  fifo_word_t wr_word, rd_word;
  logic       fifo_full, fifo_empty, pop;

  assign wr_word = '{tuser: sof, tlast: line_end, tdata: hold_px};
  assign pop     = !fifo_empty && m_axis.tready;

  sync_fifo_fwft #(
    .WID   ($bits(fifo_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (wr_word),
    .rd_en   (m_axis.tready),
    .rd_data (rd_word),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Stale head contents are masked so the stream reads all-zero when idle
  assign m_axis.tvalid = !fifo_empty;
  assign m_axis.tdata  = fifo_empty ? '0 : rd_word.tdata;
  assign m_axis.tuser  = !fifo_empty && rd_word.tuser;
  assign m_axis.tlast  = !fifo_empty && rd_word.tlast;
  assign m_axis.tkeep  = 3'b111;

  logic [CNT_WID-1:0] pix_ctr, line_ctr, pix_ctr_inc, line_ctr_inc;

  assign pix_ctr_inc  = (&pix_ctr)  ? pix_ctr  : pix_ctr  + CNT_WID'(1);
  assign line_ctr_inc = (&line_ctr) ? line_ctr : line_ctr + CNT_WID'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_ctr   <= '0;
      line_ctr  <= '0;
      pix_cnt   <= '0;
      line_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      if (line_end) begin
        pix_ctr <= '0;
        if (push) pix_cnt <= pix_ctr_inc;
      end else if (push) begin
        pix_ctr <= pix_ctr_inc;
      end
      if (frame_end) begin
        line_ctr  <= '0;
        line_cnt  <= push ? line_ctr_inc : line_ctr;
        frame_cnt <= frame_cnt + 16'd1;
      end else if (push && line_end) begin
        line_ctr <= line_ctr_inc;
      end
    end
  end

  logic ovf_set, odd_set;

  // A push into a full FIFO survives only if the same cycle pops a word
  assign ovf_set = push && fifo_full && !pop;
  assign odd_set = active && hr_fall && phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf     <= 1'b0;
      odd_err <= 1'b0;
    end else begin
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (odd_set)      odd_err <= 1'b1;
      else if (ovf_clr) odd_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cam_dvp2axis.sv
// Directed bench for cam_dvp2axis: frame skipping, RGB expansion, odd lines,
// overflow, cap_en drop and mid-line reset, with hand-computed expectations.
module tb_cam_dvp2axis;
  import cam_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cap_en = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        cam_vsync = 1'b1;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = '0;
  logic [15:0] frame_cnt;
  logic [11:0] line_cnt, pix_cnt;
  logic        ovf, odd_err;

  cam_dvp2axis_if axis ();

  cam_dvp2axis #(
    .FIFO_DEPTH  (16),
    .SKIP_FRAMES (2),
    .CNT_WID     (12)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cap_en    (cap_en),
    .ovf_clr   (ovf_clr),
    .cam_vsync (cam_vsync),
    .cam_href  (cam_href),
    .cam_data  (cam_data),
    .m_axis    (axis.master),
    .frame_cnt (frame_cnt),
    .line_cnt  (line_cnt),
    .pix_cnt   (pix_cnt),
    .ovf       (ovf),
    .odd_err   (odd_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        tuser;
    logic        tlast;
    logic [23:0] tdata;
  } beat_t;

  beat_t       beats[$];
  logic [15:0] line_px[$];
  int          n_checks = 0;
  int          n_pass = 0;

  // Inputs change 1 time unit after posedge, so at negedge tvalid/tready show the coming handshake
  always @(negedge clk) begin
    if (!rst && axis.tvalid && axis.tready)
      beats.push_back('{axis.tuser, axis.tlast, axis.tdata});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic beat_t beat_at(input int i);
    return (i < beats.size()) ? beats[i] : '0;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    cam_href = 1'b1;
    cam_data = b;
    tick();
  endtask

  task automatic set_line(input logic [15:0] px, input int n);
    line_px.delete();
    for (int i = 0; i < n; i++) line_px.push_back(px);
  endtask

  task automatic send_line(input bit extra, input int rst_at);
    foreach (line_px[i]) begin
      send_byte(line_px[i][15:8]);
      send_byte(line_px[i][7:0]);
      if (i == rst_at) begin
        check("pre_rst_tvalid", 32'(axis.tvalid), 1);
        rst = 1'b1;
        tick();
        check("rst_tvalid", 32'(axis.tvalid), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        check("rst_line_cnt", 32'(line_cnt), 0);
        check("rst_pix_cnt", 32'(pix_cnt), 0);
        rst = 1'b0;
      end
    end
    if (extra) send_byte(8'hEE);
    cam_href = 1'b0;
    tick(4);
  endtask

  task automatic send_frame(input int lines, input bit extra = 1'b0, input int drop_line = -1,
                            input int rst_line = -1, input int rst_pix = -1);
    cam_vsync = 1'b0;
    tick(4);
    for (int l = 0; l < lines; l++) begin
      if (l == drop_line) cap_en = 1'b0;
      send_line(extra, (l == rst_line) ? rst_pix : -1);
    end
    cam_vsync = 1'b1;
    tick(6);
  endtask

  task automatic check_frame(input string tag, input int n, input int ppl, input logic [23:0] px);
    beat_t b;
    check({tag, "_beats"}, 32'(beats.size()), 32'(n));
    for (int i = 0; i < beats.size(); i++) begin
      b = beats[i];
      check({tag, "_tdata"}, 32'(b.tdata), 32'(px));
      check({tag, "_tuser"}, 32'(b.tuser), 32'(i == 0));
      check({tag, "_tlast"}, 32'(b.tlast), 32'((i % ppl) == ppl - 1));
    end
  endtask

  task automatic pulse_clr();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    beat_t b;
    int    n_last;
    axis.tready = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(2);

    check("reset_tvalid", 32'(axis.tvalid), 0);
    check("reset_tdata", 32'(axis.tdata), 0);
    check("reset_tuser", 32'(axis.tuser), 0);
    check("reset_tlast", 32'(axis.tlast), 0);
    check("reset_tkeep", 32'(axis.tkeep), 32'h7);
    check("reset_frame_cnt", 32'(frame_cnt), 0);
    check("reset_line_cnt", 32'(line_cnt), 0);
    check("reset_pix_cnt", 32'(pix_cnt), 0);
    check("reset_ovf", 32'(ovf), 0);
    check("reset_odd_err", 32'(odd_err), 0);
    check("reset_state", 32'(dut.state), 32'(S_IDLE));

    // Two settling frames are dropped, the third (red) is forwarded
    cap_en = 1'b1;
    tick(4);
    beats.delete();
    set_line(16'h07E0, 4);
    send_frame(2);
    send_frame(2);
    check("skip_beats", 32'(beats.size()), 0);
    check("skip_frame_cnt", 32'(frame_cnt), 0);
    set_line(16'hF800, 4);
    send_frame(2);
    check_frame("red", 8, 4, 24'hFF0000);
    check("red_frame_cnt", 32'(frame_cnt), 1);
    check("red_line_cnt", 32'(line_cnt), 2);
    check("red_pix_cnt", 32'(pix_cnt), 4);
    check("red_ovf", 32'(ovf), 0);
    check("red_odd_err", 32'(odd_err), 0);

    // 5-byte line: 0xA5C3 -> {A5,18,BA}, 0x001F -> {00,FF,00}, trailing byte dropped
    beats.delete();
    line_px = '{16'hA5C3, 16'h001F};
    send_frame(1, 1'b1);
    check("odd_beats", 32'(beats.size()), 2);
    b = beat_at(0);
    check("odd_b0_tdata", 32'(b.tdata), 32'hA518BA);
    check("odd_b0_tuser", 32'(b.tuser), 1);
    check("odd_b0_tlast", 32'(b.tlast), 0);
    b = beat_at(1);
    check("odd_b1_tdata", 32'(b.tdata), 32'h00FF00);
    check("odd_b1_tuser", 32'(b.tuser), 0);
    check("odd_b1_tlast", 32'(b.tlast), 1);
    check("odd_err_set", 32'(odd_err), 1);
    check("odd_pix_cnt", 32'(pix_cnt), 2);
    check("odd_line_cnt", 32'(line_cnt), 1);
    check("odd_frame_cnt", 32'(frame_cnt), 2);
    pulse_clr();
    check("odd_err_clr", 32'(odd_err), 0);

    // 32-pixel line into a stalled 16-deep FIFO; pixel i has R5 = i
    beats.delete();
    axis.tready = 1'b0;
    line_px.delete();
    for (int i = 0; i < 32; i++) line_px.push_back(16'(i << 11));
    send_frame(1);
    check("ovf_set", 32'(ovf), 1);
    check("ovf_tvalid", 32'(axis.tvalid), 1);
    check("ovf_stalled_beats", 32'(beats.size()), 0);
    check("ovf_frame_cnt", 32'(frame_cnt), 3);
    axis.tready = 1'b1;
    tick(24);
    check("ovf_drain_beats", 32'(beats.size()), 16);
    b = beat_at(0);
    check("ovf_b0_tdata", 32'(b.tdata), 32'h000000);
    check("ovf_b0_tuser", 32'(b.tuser), 1);
    b = beat_at(15);
    check("ovf_b15_tdata", 32'(b.tdata), 32'h7B0000);
    n_last = 0;
    foreach (beats[i]) if (beats[i].tlast) n_last++;
    check("ovf_no_tlast", 32'(n_last), 0);
    check("ovf_drained", 32'(axis.tvalid), 0);
    pulse_clr();
    check("ovf_clr", 32'(ovf), 0);

    // cap_en drops during line 1: frame still completes, nothing follows
    beats.delete();
    set_line(16'hF800, 4);
    send_frame(2, 1'b0, 1);
    check_frame("drop", 8, 4, 24'hFF0000);
    check("drop_frame_cnt", 32'(frame_cnt), 4);
    check("drop_state", 32'(dut.state), 32'(S_IDLE));
    beats.delete();
    send_frame(2);
    check("drop_next_beats", 32'(beats.size()), 0);
    check("drop_next_frame_cnt", 32'(frame_cnt), 4);
    check("drop_next_state", 32'(dut.state), 32'(S_IDLE));

    // Re-enable: two skip frames, then reset in the middle of a captured line
    cap_en = 1'b1;
    tick(4);
    beats.delete();
    set_line(16'h07E0, 4);
    send_frame(1);
    send_frame(1);
    check("pre_rst_skip_beats", 32'(beats.size()), 0);
    axis.tready = 1'b0;
    send_frame(1, 1'b0, -1, 0, 2);
    axis.tready = 1'b1;
    tick(4);
    check("post_rst_beats", 32'(beats.size()), 0);

    // After reset the skip count restarts; the third full frame is captured
    set_line(16'hF800, 4);
    send_frame(2);
    send_frame(2);
    check("post_rst_skip_beats", 32'(beats.size()), 0);
    send_frame(2);
    check_frame("post_rst", 8, 4, 24'hFF0000);
    check("post_rst_frame_cnt", 32'(frame_cnt), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
